// File: rtl/instruction_fetch_queue_pkg.sv
// rtl/instruction_fetch_queue_pkg.sv - shared widths and defaults for the fetch stage
package instruction_fetch_queue_pkg;

    localparam int IFQ_PC_BITS          = 32;
    localparam int IFQ_INSTRUCTION_BITS = 32;
    localparam int IFQ_INST_ADDRS_BITS  = 10;
    localparam int IFQ_QUEUE_DEPTH      = 4;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO of {pc, instruction} with push/pop/flush
module fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int WIDTH = IFQ_PC_BITS + IFQ_INSTRUCTION_BITS,
    parameter int DEPTH = IFQ_QUEUE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);

    localparam int PTR_BITS = $clog2(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [PTR_BITS-1:0] r_wr_ptr;
    logic [PTR_BITS-1:0] r_rd_ptr;
    logic [PTR_BITS:0]   r_count;

    // Storage is cleared on reset so the head reads as zero before any fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_BITS'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PTR_BITS+1)'(1);
                2'b01:   r_count <= r_count - (PTR_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch_queue_bram.sv
// rtl/instruction_fetch_queue_bram.sv - single-port instruction RAM, 1-cycle registered read
module instruction_fetch_queue_bram #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_BITS-1:0] i_wdata,
    output logic [DATA_BITS-1:0] o_rdata
);

    logic [DATA_BITS-1:0] r_mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - fetch PC owner, BRAM issue, credit check and prefetch queue
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int PC_BITS          = IFQ_PC_BITS,
    parameter int INSTRUCTION_BITS = IFQ_INSTRUCTION_BITS,
    parameter int INST_ADDRS_BITS  = IFQ_INST_ADDRS_BITS,
    parameter int QUEUE_DEPTH      = IFQ_QUEUE_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          i_redirect,
    input  logic [PC_BITS-1:0]            i_redirect_pc,
    input  logic                          i_write_inst_mem,
    input  logic [PC_BITS-1:0]            i_inst_mem_addr,
    input  logic [INSTRUCTION_BITS-1:0]   i_inst_mem_data,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic [INSTRUCTION_BITS-1:0]   o_instruction,
    output logic [PC_BITS-1:0]            o_pc,
    output logic [PC_BITS-1:0]            o_pc_next,
    output logic [$clog2(QUEUE_DEPTH):0]  o_count
);

    localparam int CNT_BITS = $clog2(QUEUE_DEPTH) + 1;

    logic [PC_BITS-1:0]          r_fpc;
    logic [PC_BITS-1:0]          r_tag;
    logic                        r_inflight;
    logic                        w_pop;
    logic                        w_issue;
    logic [CNT_BITS:0]           w_occupancy;
    logic [CNT_BITS-1:0]         w_count;
    logic [INST_ADDRS_BITS-1:0]  w_mem_addr;
    logic [INSTRUCTION_BITS-1:0] w_mem_rdata;
    logic                        w_unused_addr_bits;

    assign o_valid = enable & (w_count != '0);
    assign w_pop   = o_valid & i_ready;

    // Credit: entries held plus the read still in the BRAM pipe, minus what leaves this cycle.
    assign w_occupancy = {1'b0, w_count} + {{CNT_BITS{1'b0}}, r_inflight}
                       - {{CNT_BITS{1'b0}}, w_pop};
    assign w_issue = enable & ~i_write_inst_mem & ~i_redirect
                   & (w_occupancy < (CNT_BITS+1)'(QUEUE_DEPTH));

    assign w_mem_addr = i_write_inst_mem ? i_inst_mem_addr[INST_ADDRS_BITS-1:0]
                                         : r_fpc[INST_ADDRS_BITS-1:0];
    assign w_unused_addr_bits = ^i_inst_mem_addr;

    // A redirect suppresses issue, so the next cycle has nothing in flight to push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpc      <= '0;
            r_tag      <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag <= r_fpc;
            end
            if (i_redirect) begin
                r_fpc <= i_redirect_pc;
            end else if (w_issue) begin
                r_fpc <= r_fpc + PC_BITS'(1);
            end
        end
    end

    instruction_fetch_queue_bram #(
        .DATA_BITS (INSTRUCTION_BITS),
        .ADDR_BITS (INST_ADDRS_BITS)
    ) u_bram (
        .clk     (clk),
        .i_we    (i_write_inst_mem),
        .i_addr  (w_mem_addr),
        .i_wdata (i_inst_mem_data),
        .o_rdata (w_mem_rdata)
    );

    fetch_queue #(
        .WIDTH (PC_BITS + INSTRUCTION_BITS),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data ({r_tag, w_mem_rdata}),
        .i_pop       (w_pop),
        .i_flush     (i_redirect),
        .o_count     (w_count),
        .o_head      ({o_pc, o_instruction})
    );

    assign o_pc_next = o_pc + PC_BITS'(1);
    assign o_count   = w_count;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - scoreboard bench for instruction_fetch_queue
module tb_instruction_fetch_queue;

    localparam int PCB = 6;
    localparam int IB  = 32;
    localparam int AB  = 6;
    localparam int QD  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic           i_redirect;
    logic [PCB-1:0] i_redirect_pc;
    logic           i_write_inst_mem;
    logic [PCB-1:0] i_inst_mem_addr;
    logic [IB-1:0]  i_inst_mem_data;
    logic           i_ready;
    logic           o_valid;
    logic [IB-1:0]  o_instruction;
    logic [PCB-1:0] o_pc;
    logic [PCB-1:0] o_pc_next;
    logic [2:0]     o_count;

    typedef struct packed {
        logic [PCB-1:0] pc;
        logic [IB-1:0]  inst;
    } exp_t;

    exp_t          sb[$];
    logic [IB-1:0] mem_model [64];
    int            checks   = 0;
    int            failures = 0;
    int            win      = 0;
    bit            dbg_pending = 0;

    always #5 clk = ~clk;

    instruction_fetch_queue #(
        .PC_BITS          (PCB),
        .INSTRUCTION_BITS (IB),
        .INST_ADDRS_BITS  (AB),
        .QUEUE_DEPTH      (QD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .i_write_inst_mem (i_write_inst_mem),
        .i_inst_mem_addr  (i_inst_mem_addr),
        .i_inst_mem_data  (i_inst_mem_data),
        .i_ready          (i_ready),
        .o_valid          (o_valid),
        .o_instruction    (o_instruction),
        .o_pc             (o_pc),
        .o_pc_next        (o_pc_next),
        .o_count          (o_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Expected stream after a restart: consecutive PCs from start, words from the memory image.
    function automatic void refill(input logic [PCB-1:0] start);
        exp_t e;
        sb.delete();
        for (int k = 0; k < 64; k++) begin
            e.pc   = start + PCB'(k);
            e.inst = mem_model[e.pc];
            sb.push_back(e);
        end
    endfunction

    task automatic restart_latency(input string tag);
        mid();  chk({tag, "_valid_c0"}, 64'(o_valid), 64'(0));
        tick(); mid(); chk({tag, "_valid_c1"}, 64'(o_valid), 64'(0));
        tick(); mid(); chk({tag, "_valid_c2"}, 64'(o_valid), 64'(1));
    endtask

    initial begin : monitor
        exp_t           e;
        logic [PCB-1:0] nx;
        forever begin
            @(negedge clk);
            if (rst && o_valid && i_ready && !i_redirect) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: got pc 0x%0h expected no output", o_pc);
                end else begin
                    e  = sb.pop_front();
                    nx = e.pc + PCB'(1);
                    chk("pop_pc", 64'(o_pc), 64'(e.pc));
                    chk("pop_inst", 64'(o_instruction), 64'(e.inst));
                    chk("pop_pc_next", 64'(o_pc_next), 64'(nx));
                end
            end
            if (rst) begin
                chk("count_bound", 64'(o_count <= 3'(QD)), 64'(1));
            end
        end
    end

    initial begin : stimulus
        logic [PCB-1:0] a;
        logic [IB-1:0]  d;
        rst = 1'b0; enable = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
        i_write_inst_mem = 1'b0; i_inst_mem_addr = '0; i_inst_mem_data = '0; i_ready = 1'b0;

        tick();
        for (int k = 0; k < 64; k++) begin
            i_write_inst_mem = 1'b1;
            i_inst_mem_addr  = PCB'(k);
            i_inst_mem_data  = 32'h1000 + k;
            mem_model[k]     = 32'h1000 + k;
            tick();
        end
        i_write_inst_mem = 1'b0;
        mid();
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_count", 64'(o_count), 64'(0));
        chk("rst_pc", 64'(o_pc), 64'(0));
        chk("rst_pc_next", 64'(o_pc_next), 64'(1));
        chk("rst_inst", 64'(o_instruction), 64'(0));

        tick();
        enable = 1'b1; i_ready = 1'b1;
        refill('0);
        rst = 1'b1;
        restart_latency("seq");
        repeat (5) tick();

        i_ready = 1'b0;
        repeat (10) tick();
        mid();
        chk("bp_count_full", 64'(o_count), 64'(QD));
        chk("bp_valid", 64'(o_valid), 64'(1));
        tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0; i_redirect = 1'b1; i_redirect_pc = 6'h20;
        refill(6'h20);
        mid();
        chk("rd_count_before", 64'(o_count), 64'(3));
        tick();
        i_redirect = 1'b0; i_ready = 1'b1;
        mid();
        chk("rd_valid_r1", 64'(o_valid), 64'(0));
        chk("rd_count_r1", 64'(o_count), 64'(0));
        tick(); mid(); chk("rd_valid_r2", 64'(o_valid), 64'(0));
        tick(); mid(); chk("rd_valid_r3", 64'(o_valid), 64'(1));
        chk("rd_pc_r3", 64'(o_pc), 64'(6'h20));
        repeat (3) tick();

        enable = 1'b0;
        tick();
        i_write_inst_mem = 1'b1; i_inst_mem_addr = 6'd5; i_inst_mem_data = 32'hDEADBEEF;
        mem_model[5] = 32'hDEADBEEF;
        mid();
        chk("dbg_valid_off", 64'(o_valid), 64'(0));
        tick();
        i_write_inst_mem = 1'b0; i_redirect = 1'b1; i_redirect_pc = 6'd5;
        refill(6'd5);
        tick();
        i_redirect = 1'b0; enable = 1'b1;
        restart_latency("dbg");
        chk("dbg_pc", 64'(o_pc), 64'(5));
        chk("dbg_inst", 64'(o_instruction), 64'(32'hDEADBEEF));

        repeat (2) tick();
        i_redirect = 1'b1; i_redirect_pc = 6'h3E;
        refill(6'h3E);
        tick();
        i_redirect = 1'b0;
        repeat (4) tick();
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("en_low_valid", 64'(o_valid), 64'(0));
            tick();
        end
        enable = 1'b1;
        repeat (6) tick();

        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(o_valid), 64'(0));
        chk("arst_count", 64'(o_count), 64'(0));
        chk("arst_pc", 64'(o_pc), 64'(0));
        chk("arst_pc_next", 64'(o_pc_next), 64'(1));
        chk("arst_inst", 64'(o_instruction), 64'(0));
        tick();
        rst = 1'b1;
        refill('0);
        restart_latency("arst");

        win = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            win++;
            i_redirect       = 1'b0;
            i_write_inst_mem = 1'b0;
            i_ready          = ($urandom % 4) != 0;
            enable           = ($urandom % 10) != 0;
            if (dbg_pending) begin
                enable        = 1'b0;
                i_redirect    = 1'b1;
                i_redirect_pc = PCB'($urandom);
                refill(i_redirect_pc);
                dbg_pending   = 1'b0;
                win           = 0;
            end else if (win >= 50 || ($urandom % 40) == 0) begin
                i_redirect    = 1'b1;
                i_redirect_pc = PCB'($urandom);
                refill(i_redirect_pc);
                win           = 0;
            end else if (($urandom % 60) == 0) begin
                a = PCB'($urandom);
                d = $urandom;
                enable           = 1'b0;
                i_write_inst_mem = 1'b1;
                i_inst_mem_addr  = a;
                i_inst_mem_data  = d;
                mem_model[a]     = d;
                dbg_pending      = 1'b1;
            end
        end
        tick();
        i_redirect = 1'b0; i_write_inst_mem = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
